// File: rtl/floor_request_queue.sv
// -----------------------------------------------------------------------------
// floor_request_queue
//
// Input stage ahead of the elevator controller. The raw call button and the
// floor switches are synchronised, the button is debounced, and each clean
// 0->1 transition of the debounced button becomes one floor request. Requests
// are held in a small FIFO and presented to the controller with a valid/ready
// handshake. A press whose floor is already queued, or that arrives while the
// queue is full and nothing is leaving, is discarded and flagged on drop_pulse.
//
// Ports
//   sys_clk      in   system clock, all logic on the rising edge
//   sys_rst      in   asynchronous active-low reset
//   valid        in   raw call button (active high, asynchronous, bouncy)
//   SW           in   raw requested-floor switches (asynchronous)
//   req_ready    in   controller takes the head request this cycle
//   req_valid    out  queue non-empty, head request presented
//   req_floor    out  head request floor (meaningless while req_valid=0)
//   queue_count  out  number of held entries
//   queue_full   out  queue_count == DEPTH
//   drop_pulse   out  one-cycle pulse when a press is discarded
// -----------------------------------------------------------------------------
module floor_request_queue #(
  parameter int FLOOR_W      = 3,
  parameter int DEPTH        = 4,
  parameter int DEBOUNCE_CYC = 500000
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst,
  input  logic                       valid,
  input  logic [FLOOR_W-1:0]         SW,
  input  logic                       req_ready,
  output logic                       req_valid,
  output logic [FLOOR_W-1:0]         req_floor,
  output logic [$clog2(DEPTH+1)-1:0] queue_count,
  output logic                       queue_full,
  output logic                       drop_pulse
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int DB_W  = $clog2(DEBOUNCE_CYC);

  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  // ---------------------------------------------------------------------------
  // Two-flop synchronisers for the button and every switch bit
  // ---------------------------------------------------------------------------
  logic               v_meta_reg;
  logic               v_s_reg;
  logic [FLOOR_W-1:0] sw_meta_reg;
  logic [FLOOR_W-1:0] sw_s_reg;

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      v_meta_reg <= 1'b0;
      v_s_reg    <= 1'b0;
    end else begin
      v_meta_reg <= valid;
      v_s_reg    <= v_meta_reg;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < FLOOR_W; gi++) begin : g_sw_sync
      always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
          sw_meta_reg[gi] <= 1'b0;
          sw_s_reg[gi]    <= 1'b0;
        end else begin
          sw_meta_reg[gi] <= SW[gi];
          sw_s_reg[gi]    <= sw_meta_reg[gi];
        end
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Debounce: the synchronised button must disagree with the accepted level
  // for DEBOUNCE_CYC consecutive cycles before the level follows it. Any cycle
  // of agreement restarts the count, so short glitches never get through.
  // ---------------------------------------------------------------------------
  logic [DB_W-1:0] db_cnt_reg;
  logic            level_reg;
  logic            level_d_reg;
  logic            press;

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      db_cnt_reg  <= '0;
      level_reg   <= 1'b0;
      level_d_reg <= 1'b0;
    end else begin
      level_d_reg <= level_reg;
      if (v_s_reg == level_reg) begin
        db_cnt_reg <= '0;
      end else if (db_cnt_reg == DB_LAST) begin
        level_reg  <= v_s_reg;
        db_cnt_reg <= '0;
      end else begin
        db_cnt_reg <= db_cnt_reg + 1'b1;
      end
    end
  end

  // One-cycle strobe on the rising edge of the debounced level; releases and
  // long holds produce nothing further.
  assign press = level_reg & ~level_d_reg;

  // ---------------------------------------------------------------------------
  // FIFO state
  // ---------------------------------------------------------------------------
  logic [FLOOR_W-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_reg;
  logic [PTR_W-1:0]   rd_ptr_reg;
  logic [CNT_W-1:0]   count_reg;
  logic               req_valid_reg;
  logic [FLOOR_W-1:0] req_floor_reg;
  logic               queue_full_reg;
  logic               drop_reg;

  logic               pop;
  logic               full_now;
  logic               dup;
  logic               push;
  logic               drop_next;
  logic [DEPTH-1:0]   slot_match;
  logic [PTR_W-1:0]   wr_ptr_next;
  logic [PTR_W-1:0]   rd_ptr_next;
  logic [CNT_W-1:0]   count_next;
  logic [FLOOR_W-1:0] head_next;

  // A slot is held when its distance from the read pointer (mod DEPTH) is
  // below the occupancy. The head is included even if it is leaving this
  // cycle, so re-pressing the floor being served is still a duplicate.
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_dup
      logic [PTR_W-1:0] slot_offset;
      logic             slot_held;
      assign slot_offset    = PTR_W'(gi) - rd_ptr_reg;
      assign slot_held      = CNT_W'(slot_offset) < count_reg;
      assign slot_match[gi] = slot_held && (mem_reg[gi] == sw_s_reg);
    end
  endgenerate

  always_comb begin
    pop       = req_valid_reg & req_ready;
    full_now  = (count_reg == CNT_FULL);
    dup       = |slot_match;
    // A full queue still accepts a press when the head leaves in the same cycle.
    push      = press & ~dup & (~full_now | pop);
    drop_next = press & (dup | (full_now & ~pop));

    wr_ptr_next = wr_ptr_reg + PTR_W'(push);
    rd_ptr_next = rd_ptr_reg + PTR_W'(pop);

    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase

    // The new head is the incoming floor when it lands exactly where the read
    // pointer will be (queue empty, or its last entry leaving); otherwise it
    // is already in storage.
    if (push && (wr_ptr_reg == rd_ptr_next)) begin
      head_next = sw_s_reg;
    end else begin
      head_next = mem_reg[rd_ptr_next];
    end
  end

  // Storage array carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge sys_clk) begin
    if (push) begin
      mem_reg[wr_ptr_reg] <= sw_s_reg;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      req_valid_reg  <= 1'b0;
      req_floor_reg  <= '0;
      queue_full_reg <= 1'b0;
      drop_reg       <= 1'b0;
    end else begin
      wr_ptr_reg     <= wr_ptr_next;
      rd_ptr_reg     <= rd_ptr_next;
      count_reg      <= count_next;
      req_valid_reg  <= (count_next != '0);
      req_floor_reg  <= head_next;
      queue_full_reg <= (count_next == CNT_FULL);
      drop_reg       <= drop_next;
    end
  end

  assign req_valid   = req_valid_reg;
  assign req_floor   = req_floor_reg;
  assign queue_count = count_reg;
  assign queue_full  = queue_full_reg;
  assign drop_pulse  = drop_reg;

endmodule

// File: tb/tb_floor_request_queue.sv
// -----------------------------------------------------------------------------
// tb_floor_request_queue
//
// Directed bench for floor_request_queue with a short debounce window. A
// queue-based model applies the request rules (duplicate, full, full-with-pop,
// ordering) at the edge where each press is due, and a compare process checks
// every output against it on every falling edge. Literal expectations pin the
// latency, ordering and drop behaviour of the model itself.
// -----------------------------------------------------------------------------
module tb_floor_request_queue;

  localparam int FW    = 3;
  localparam int DEPTH = 4;
  localparam int DB    = 8;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          sys_rst;
  logic          valid;
  logic [FW-1:0] sw;
  logic          req_ready;
  logic          req_valid;
  logic [FW-1:0] req_floor;
  logic [CW-1:0] queue_count;
  logic          queue_full;
  logic          drop_pulse;

  always #5 clk = ~clk;

  floor_request_queue #(
    .FLOOR_W      (FW),
    .DEPTH        (DEPTH),
    .DEBOUNCE_CYC (DB)
  ) dut (
    .sys_clk     (clk),
    .sys_rst     (sys_rst),
    .valid       (valid),
    .SW          (sw),
    .req_ready   (req_ready),
    .req_valid   (req_valid),
    .req_floor   (req_floor),
    .queue_count (queue_count),
    .queue_full  (queue_full),
    .drop_pulse  (drop_pulse)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int drops_total = 0;
  bit chk_en = 0;

  // Model state
  int model_q[$];
  bit model_drop = 0;
  bit pend = 0;
  int pend_cyc = 0;
  int pend_floor = 0;
  int got[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: a clean press lands DB+3 edges after the raw rising edge.
  always @(posedge clk or negedge sys_rst) begin
    if (!sys_rst) begin
      model_q.delete();
      model_drop = 0;
      pend = 0;
    end else begin
      bit pop_now, ev, dup_now, full_now;
      cyc++;
      pop_now = (model_q.size() > 0) && req_ready;
      ev = pend && (cyc == pend_cyc);
      model_drop = 0;
      if (ev) begin
        pend = 0;
        dup_now = 0;
        foreach (model_q[i]) if (model_q[i] == pend_floor) dup_now = 1;
        full_now = (model_q.size() == DEPTH);
        if (dup_now || (full_now && !pop_now)) model_drop = 1;
      end
      if (pop_now) void'(model_q.pop_front());
      if (ev && !model_drop) model_q.push_back(pend_floor);
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("req_valid", int'(req_valid), int'(model_q.size() != 0));
      chk("queue_count", int'(queue_count), model_q.size());
      chk("queue_full", int'(queue_full), int'(model_q.size() == DEPTH));
      chk("drop_pulse", int'(drop_pulse), int'(model_drop));
      if (model_q.size() != 0) chk("req_floor", int'(req_floor), model_q[0]);
      if (drop_pulse) drops_total++;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Press and release the button for floor f. With pop_same, req_ready is
  // raised for exactly the edge where the press is due.
  task automatic press(input int f, input bit pop_same);
    sw = FW'(f);
    valid = 1'b1;
    pend_floor = f;
    pend_cyc = cyc + DB + 3;
    pend = 1;
    if (pop_same) begin
      step(DB + 2);
      req_ready = 1'b1;
      step(1);
      req_ready = 1'b0;
      step(3);
    end else begin
      step(DB + 6);
    end
    valid = 1'b0;
    step(DB + 6);
  endtask

  // Pop everything, recording the head at each pop.
  task automatic drain(input string name);
    bit done;
    done = 0;
    got.delete();
    req_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!req_valid) begin
        done = 1;
        break;
      end
      got.push_back(int'(req_floor));
    end
    chk({name, "_drained"}, int'(done), 1);
    @(posedge clk);
    #2;
    req_ready = 1'b0;
  endtask

  task automatic chk_got4(input string name, input int a, input int b, input int c, input int d);
    int exp[4];
    exp = '{a, b, c, d};
    chk({name, "_len"}, got.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < got.size()) chk({name, "_item"}, got[i], exp[i]);
    end
  endtask

  initial begin
    int d0;
    sys_rst = 1'b1;
    valid = 1'b0;
    sw = '0;
    req_ready = 1'b0;

    // 1: reset with the button held and SW=5
    #1;
    sys_rst = 1'b0;
    sw = 3'd5;
    valid = 1'b1;
    chk_en = 1;
    @(negedge clk);
    chk("t1_rst_valid", int'(req_valid), 0);
    chk("t1_rst_count", int'(queue_count), 0);
    chk("t1_rst_full", int'(queue_full), 0);
    chk("t1_rst_drop", int'(drop_pulse), 0);
    chk("t1_rst_floor", int'(req_floor), 0);
    step(3);
    sys_rst = 1'b1;
    pend_floor = 5;
    pend_cyc = cyc + DB + 3;
    pend = 1;
    step(DB + 2);
    @(negedge clk);
    chk("t1_before_push", int'(req_valid), 0);
    @(negedge clk);
    chk("t1_after_push_count", int'(queue_count), 1);
    chk("t1_after_push_floor", int'(req_floor), 5);
    @(posedge clk);
    #2;
    valid = 1'b0;
    step(DB + 6);
    drain("t1");
    chk("t1_len", got.size(), 1);

    // 2: bouncy button, then a clean hold on floor 3
    sw = 3'd3;
    for (int i = 0; i < 10; i++) begin
      valid = ~valid;
      step(3);
    end
    chk("t2_no_push_bounce", int'(queue_count), 0);
    press(3, 0);
    @(negedge clk);
    chk("t2_count", int'(queue_count), 1);
    chk("t2_floor", int'(req_floor), 3);
    @(posedge clk);
    #2;
    drain("t2");
    chk("t2_len", got.size(), 1);

    // 3: ordering and pointer wrap
    for (int f = 1; f <= 4; f++) press(f, 0);
    @(negedge clk);
    chk("t3_count4", int'(queue_count), 4);
    chk("t3_full", int'(queue_full), 1);
    @(posedge clk);
    #2;
    req_ready = 1'b1;
    step(2);
    req_ready = 1'b0;
    @(negedge clk);
    chk("t3_count2", int'(queue_count), 2);
    chk("t3_head3", int'(req_floor), 3);
    @(posedge clk);
    #2;
    press(5, 0);
    press(6, 0);
    drain("t3");
    chk_got4("t3_seq", 3, 4, 5, 6);

    // 4: duplicate drop, then full drop
    press(2, 0);
    d0 = drops_total;
    press(2, 0);
    chk("t4_dup_drops", drops_total - d0, 1);
    chk("t4_dup_count", int'(queue_count), 1);
    press(3, 0);
    press(4, 0);
    press(5, 0);
    d0 = drops_total;
    press(7, 0);
    chk("t4_full_drops", drops_total - d0, 1);
    chk("t4_full_count", int'(queue_count), 4);
    drain("t4");
    chk_got4("t4_seq", 2, 3, 4, 5);

    // 5: press into a full queue in the same cycle as a pop
    for (int f = 1; f <= 4; f++) press(f, 0);
    d0 = drops_total;
    press(6, 1);
    chk("t5_drops", drops_total - d0, 0);
    chk("t5_count", int'(queue_count), 4);
    drain("t5");
    chk_got4("t5_seq", 2, 3, 4, 6);

    // 6: reset pulse while three entries are held
    for (int f = 1; f <= 3; f++) press(f, 0);
    chk("t6_count3", int'(queue_count), 3);
    sys_rst = 1'b0;
    @(negedge clk);
    chk("t6_rst_valid", int'(req_valid), 0);
    chk("t6_rst_count", int'(queue_count), 0);
    @(posedge clk);
    #2;
    sys_rst = 1'b1;
    @(negedge clk);
    chk("t6_post_valid", int'(req_valid), 0);
    chk("t6_post_count", int'(queue_count), 0);
    @(posedge clk);
    #2;
    press(4, 0);
    chk("t6_new_count", int'(queue_count), 1);
    chk("t6_new_floor", int'(req_floor), 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Safety net: the run must end on its own.
  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
